// File: rtl/rpath_scheduler.sv
// rpath_scheduler
// Owns the outgoing (read-side) ping-pong FIFO and shares it between two
// word sources: requester 0 (status/response writer) and requester 1 (bulk
// read-data writer). FIFO halves are activated alternately, words are counted
// per half, and a half is released when it is full or flushed. Access is
// arbitrated with fixed priority (requester 0 first) and each grant is held
// until its owner pulses done.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_req[1:0]        per-requester access request (level)
//   o_gnt[1:0]        one-hot registered grant
//   i_done[1:0]       owner releases its grant (single-cycle pulse)
//   i_stb[1:0]        per-requester word strobe, honoured only from the owner
//   i_data0, i_data1  requester words
//   o_space           a half is active and has room (combinational)
//   o_drop_stb        owner strobed with no room, word discarded (registered)
//   i_flush           request early release of a partially filled half
//   i_rpath_ready     FIFO halves free for writing
//   o_rpath_activate  active half, one-hot or zero
//   i_rpath_size      capacity of the active half in words
//   o_rpath_data      registered word to the FIFO
//   o_rpath_strobe    registered write pulse to the FIFO
module rpath_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_req,
  output logic [1:0]            o_gnt,
  input  logic [1:0]            i_done,
  input  logic [1:0]            i_stb,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_space,
  output logic                  o_drop_stb,
  input  logic                  i_flush,
  input  logic [1:0]            i_rpath_ready,
  output logic [1:0]            o_rpath_activate,
  input  logic [SIZE_WIDTH-1:0] i_rpath_size,
  output logic [DATA_WIDTH-1:0] o_rpath_data,
  output logic                  o_rpath_strobe
);

  typedef enum logic {IDLE, ACTIVE} half_state_t;

  half_state_t           state, state_nxt;
  logic [1:0]            activate_nxt;
  logic                  last_half, last_half_nxt;
  logic                  chosen;
  logic [SIZE_WIDTH-1:0] count, count_nxt;
  logic                  flush_pend, flush_pend_nxt;
  logic                  release_half;
  logic [1:0]            gnt_nxt;
  logic                  owner_stb;
  logic                  accept;
  logic [DATA_WIDTH-1:0] owner_data;

  // Only the current owner's strobe matters; non-owner strobes vanish silently.
  assign owner_stb  = |(o_gnt & i_stb);
  assign owner_data = o_gnt[1] ? i_data1 : i_data0;
  assign o_space    = (state == ACTIVE) && (count < i_rpath_size);
  assign accept     = owner_stb && o_space;

  // Half FSM next state. A flush that cannot release yet (empty half, or a
  // word being accepted this cycle) is remembered until it can.
  always_comb begin
    state_nxt      = state;
    activate_nxt   = o_rpath_activate;
    last_half_nxt  = last_half;
    count_nxt      = count;
    flush_pend_nxt = flush_pend;
    release_half   = 1'b0;
    chosen         = 1'b0;
    case (state)
      IDLE: begin
        if (i_rpath_ready != 2'b00) begin
          // With both halves free, alternate against the last one used.
          chosen         = (i_rpath_ready == 2'b11) ? ~last_half : i_rpath_ready[1];
          state_nxt      = ACTIVE;
          last_half_nxt  = chosen;
          activate_nxt   = chosen ? 2'b10 : 2'b01;
          count_nxt      = '0;
          flush_pend_nxt = 1'b0;
        end
      end
      ACTIVE: begin
        release_half = (count == i_rpath_size) ||
                       ((i_flush || flush_pend) && (count != '0) && !accept);
        if (release_half) begin
          state_nxt      = IDLE;
          activate_nxt   = 2'b00;
          flush_pend_nxt = 1'b0;
        end else begin
          if (accept) begin
            count_nxt = count + 1'b1;
          end
          flush_pend_nxt = flush_pend || i_flush;
        end
      end
      default: begin
        state_nxt    = IDLE;
        activate_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      o_rpath_activate <= 2'b00;
      last_half        <= 1'b1;
      count            <= '0;
      flush_pend       <= 1'b0;
    end else begin
      state            <= state_nxt;
      o_rpath_activate <= activate_nxt;
      last_half        <= last_half_nxt;
      count            <= count_nxt;
      flush_pend       <= flush_pend_nxt;
    end
  end

  // Grant only moves when nobody owns the FIFO; no preemption.
  always_comb begin
    gnt_nxt = o_gnt;
    if (o_gnt == 2'b00) begin
      if (i_req[0]) begin
        gnt_nxt = 2'b01;
      end else if (i_req[1]) begin
        gnt_nxt = 2'b10;
      end
    end else if ((o_gnt & i_done) != 2'b00) begin
      gnt_nxt = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_gnt          <= 2'b00;
      o_rpath_strobe <= 1'b0;
      o_rpath_data   <= '0;
      o_drop_stb     <= 1'b0;
    end else begin
      o_gnt          <= gnt_nxt;
      o_rpath_strobe <= accept;
      o_drop_stb     <= owner_stb && !o_space;
      if (accept) begin
        o_rpath_data <= owner_data;
      end
    end
  end

endmodule

// File: tb/tb_rpath_scheduler.sv
module tb_rpath_scheduler;

  localparam int DW = 32;
  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    i_req, o_gnt, i_done, i_stb, i_rpath_ready, o_rpath_activate;
  logic [DW-1:0] i_data0, i_data1, o_rpath_data;
  logic          o_space, o_drop_stb, i_flush, o_rpath_strobe;
  logic [SW-1:0] i_rpath_size;

  rpath_scheduler #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt), .i_done(i_done),
    .i_stb(i_stb), .i_data0(i_data0), .i_data1(i_data1), .o_space(o_space),
    .o_drop_stb(o_drop_stb), .i_flush(i_flush), .i_rpath_ready(i_rpath_ready),
    .o_rpath_activate(o_rpath_activate), .i_rpath_size(i_rpath_size),
    .o_rpath_data(o_rpath_data), .o_rpath_strobe(o_rpath_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } word_t;

  word_t word_q[$];
  int    drop_q[$];
  word_t mon_w;
  int    tests = 0;
  int    fails = 0;
  int    strobes_seen = 0;
  int    drops_seen = 0;

  // Staged stimulus, copied onto the DUT by applyStimulus.
  logic [1:0]    s_req, s_done, s_stb, s_ready;
  logic [DW-1:0] s_d0, s_d1;
  logic          s_flush;
  logic [SW-1:0] s_size;

  // Reference model: owner/half as -1 (none) or index, fill as a plain count.
  int   m_owner, m_half, m_last, m_fill;
  bit   m_flush_wait;
  logic [1:0] chk_gnt, chk_act;
  logic       chk_space;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] onehot(input int idx);
    if (idx < 0) return 2'b00;
    return (idx == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic modelReset();
    m_owner = -1; m_half = -1; m_last = 1; m_fill = 0; m_flush_wait = 0;
    chk_gnt = 2'b00; chk_act = 2'b00; chk_space = 1'b0;
    word_q.delete();
    drop_q.delete();
  endtask

  task automatic clearStaged();
    s_req = 0; s_done = 0; s_stb = 0; s_ready = 0;
    s_d0 = 0; s_d1 = 0; s_flush = 0; s_size = 0;
  endtask

  task automatic applyStimulus();
    bit space, ostb, accepted, full, rel;
    @(posedge clk);
    #1;
    chk_gnt = onehot(m_owner);
    chk_act = onehot(m_half);
    i_req = s_req; i_done = s_done; i_stb = s_stb; i_data0 = s_d0; i_data1 = s_d1;
    i_flush = s_flush; i_rpath_ready = s_ready; i_rpath_size = s_size;
    space     = (m_half >= 0) && (m_fill < int'(s_size));
    chk_space = space;
    ostb      = (m_owner >= 0) && s_stb[m_owner];
    accepted  = ostb && space;
    if (accepted) word_q.push_back('{data: (m_owner == 1) ? s_d1 : s_d0, due: cyc + 1});
    else if (ostb) drop_q.push_back(cyc + 1);
    if (m_half < 0) begin
      if (s_ready != 2'b00) begin
        if (s_ready == 2'b01) m_half = 0;
        else if (s_ready == 2'b10) m_half = 1;
        else m_half = 1 - m_last;
        m_last = m_half;
        m_fill = 0;
        m_flush_wait = 0;
      end
    end else begin
      full = (m_fill == int'(s_size));
      rel  = full || ((s_flush || m_flush_wait) && m_fill > 0 && !accepted);
      if (rel) begin
        m_half = -1;
        m_flush_wait = 0;
      end else begin
        if (accepted) m_fill++;
        m_flush_wait = m_flush_wait || s_flush;
      end
    end
    if (m_owner < 0) begin
      if (s_req[0]) m_owner = 0;
      else if (s_req[1]) m_owner = 1;
    end else if (s_done[m_owner]) begin
      m_owner = -1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"}, 64'(o_gnt), 64'(0));
    checkOutput({tag, "_activate"}, 64'(o_rpath_activate), 64'(0));
    checkOutput({tag, "_strobe"}, 64'(o_rpath_strobe), 64'(0));
    checkOutput({tag, "_drop"}, 64'(o_drop_stb), 64'(0));
    checkOutput({tag, "_data"}, 64'(o_rpath_data), 64'(0));
    checkOutput({tag, "_space"}, 64'(o_space), 64'(0));
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic resetPulse(input string tag);
    #1;
    rst = 1'b1;
    clearStaged();
    i_req = 0; i_done = 0; i_stb = 0; i_data0 = 0; i_data1 = 0;
    i_flush = 0; i_rpath_ready = 0; i_rpath_size = 0;
    #1;
    checkResetOutputs(tag);
    modelReset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares registered outputs against the model and pops words
  // and drop pulses from the scoreboard as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("gnt", 64'(o_gnt), 64'(chk_gnt));
      checkOutput("activate", 64'(o_rpath_activate), 64'(chk_act));
      checkOutput("space", 64'(o_space), 64'(chk_space));
      if (o_rpath_strobe) begin
        strobes_seen++;
        if (word_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_word: got data 0x%0h, expected no strobe (cycle %0d)", o_rpath_data, cyc);
        end else begin
          mon_w = word_q.pop_front();
          checkOutput("word_data", 64'(o_rpath_data), 64'(mon_w.data));
          checkOutput("word_cycle", 64'(cyc), 64'(mon_w.due));
        end
      end else if (word_q.size() > 0 && word_q[0].due <= cyc) begin
        mon_w = word_q.pop_front();
        tests++; fails++;
        $display("[TB] FAIL missing_word: got no strobe, expected data 0x%0h (cycle %0d)", mon_w.data, cyc);
      end
      if (o_drop_stb) begin
        drops_seen++;
        if (drop_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_drop: got drop pulse, expected none (cycle %0d)", cyc);
        end else begin
          checkOutput("drop_cycle", 64'(cyc), 64'(drop_q.pop_front()));
        end
      end else if (drop_q.size() > 0 && drop_q[0] <= cyc) begin
        void'(drop_q.pop_front());
        tests++; fails++;
        $display("[TB] FAIL missing_drop: got no pulse, expected drop (cycle %0d)", cyc);
      end
    end
  end

  int base_words, base_drops;
  int sizes[4] = '{5, 0, 1, 3};

  initial begin
    rst = 1'b1;
    clearStaged();
    i_req = 0; i_done = 0; i_stb = 0; i_data0 = 0; i_data1 = 0;
    i_flush = 0; i_rpath_ready = 0; i_rpath_size = 0;
    modelReset();
    #2;
    checkResetOutputs("reset");
    #10;
    rst = 1'b0;

    // Ping-pong: half 0 first, requester 1 writes 0xA0..0xA3, then half 1.
    base_words = strobes_seen;
    s_ready = 2'b11; s_size = 4; s_req = 2'b10;
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      s_stb = 2'b10; s_d1 = 32'hA0 + i;
      applyStimulus();
    end
    s_stb = 2'b00; s_done = 2'b10;
    applyStimulus();
    s_done = 2'b00; s_req = 2'b00;
    ticks(4);
    checkOutput("pingpong_words", 64'(strobes_seen - base_words), 64'(4));
    checkOutput("pingpong_second_half", 64'(o_rpath_activate), 64'(2'b10));

    // Simultaneous requests, requester 0 first, handover after done.
    s_req = 2'b11;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      s_stb = 2'b01; s_d0 = 32'hB0 + i; s_d1 = 32'hDEAD0000 + i;
      s_done = (i == 2) ? 2'b01 : 2'b00;
      applyStimulus();
    end
    s_stb = 2'b00; s_done = 2'b00; s_req = 2'b10;
    ticks(2);
    s_stb = 2'b10; s_d1 = 32'hB8;
    applyStimulus();
    s_stb = 2'b00; s_done = 2'b10; s_req = 2'b00;
    applyStimulus();
    s_done = 2'b00;
    ticks(3);

    // Overrun: size 2, three consecutive strobes, third dropped.
    resetPulse("reset_scn3");
    base_drops = drops_seen;
    s_ready = 2'b01; s_size = 2; s_req = 2'b01;
    ticks(2);
    for (int i = 0; i < 3; i++) begin
      s_stb = 2'b01; s_d0 = 32'hC0 + i;
      applyStimulus();
    end
    s_stb = 2'b00; s_ready = 2'b00;
    ticks(3);
    checkOutput("overrun_drops", 64'(drops_seen - base_drops), 64'(1));

    // Flush on an empty half waits for a word; flush with a strobe defers.
    resetPulse("reset_scn4");
    s_ready = 2'b01; s_size = 8; s_req = 2'b01;
    applyStimulus();
    s_ready = 2'b00;
    applyStimulus();
    s_flush = 1'b1;
    applyStimulus();
    s_flush = 1'b0;
    ticks(2);
    s_stb = 2'b01; s_d0 = 32'hD0;
    applyStimulus();
    s_stb = 2'b00;
    ticks(3);
    s_ready = 2'b01;
    applyStimulus();
    s_ready = 2'b00;
    ticks(2);
    s_stb = 2'b01; s_d0 = 32'hD1;
    applyStimulus();
    s_stb = 2'b01; s_d0 = 32'hD2; s_flush = 1'b1;
    applyStimulus();
    s_stb = 2'b00; s_flush = 1'b0;
    ticks(3);

    // Mid-packet reset with count=3, then half 0 chosen first again.
    resetPulse("reset_scn5a");
    s_ready = 2'b11; s_size = 8; s_req = 2'b10;
    ticks(2);
    for (int i = 0; i < 3; i++) begin
      s_stb = 2'b10; s_d1 = 32'hE0 + i;
      applyStimulus();
    end
    s_stb = 2'b00;
    applyStimulus();
    resetPulse("reset_midpacket");
    s_ready = 2'b11; s_size = 8;
    ticks(3);
    checkOutput("after_reset_half0", 64'(o_rpath_activate), 64'(2'b01));

    // Randomized traffic across several half sizes, including zero.
    for (int p = 0; p < 4; p++) begin
      resetPulse("reset_rand");
      for (int i = 0; i < 300; i++) begin
        s_req   = 2'($urandom_range(0, 3));
        s_done  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        s_stb   = 2'($urandom_range(0, 3));
        s_d0    = $urandom;
        s_d1    = $urandom;
        s_flush = ($urandom_range(0, 9) == 0);
        s_ready = 2'($urandom_range(0, 3));
        s_size  = SW'(sizes[p]);
        applyStimulus();
      end
    end

    clearStaged();
    ticks(4);
    checkOutput("words_pending", 64'(word_q.size()), 64'(0));
    checkOutput("drops_pending", 64'(drop_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
